// File: rtl/sram_like_data_responder_if.sv
// SRAM-like data port bundle (req / addr_ok / data_ok) between the
// pipeline's data master and a memory-side responder.
//   data_sram_req     : request valid                    (master -> slave)
//   data_sram_wr      : 1 = store, 0 = load              (master -> slave)
//   data_sram_size    : access size                      (master -> slave)
//   data_sram_wstrb   : store byte enables               (master -> slave)
//   data_sram_addr    : byte address                     (master -> slave)
//   data_sram_wdata   : lane-aligned store data          (master -> slave)
//   data_sram_addr_ok : request accepted when high with req (slave -> master)
//   data_sram_data_ok : response valid, no backpressure  (slave -> master)
//   data_sram_rdata   : load data, 0 for stores          (slave -> master)
interface sram_like_data_responder_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/sram_like_data_responder.sv
// Slave-side responder for the SRAM-like data interface. Loads and stores
// are performed on an internal word-organised RAM; one data_ok pulse is
// returned per accepted request, in order, no earlier than LATENCY cycles
// after acceptance.
// Parameters:
//   AW      : log2 of RAM depth in 32-bit words (at most 29)
//   DEPTH   : max outstanding requests (power of 2, >= 2)
//   LATENCY : min cycles from accept to data_ok (1..15)
// Ports:
//   clk         : single clock, rising edge
//   resetn      : asynchronous active-low reset
//   bus         : SRAM-like data port, slave side
//   outstanding : number of queued responses
module sram_like_data_responder #(
  parameter int AW      = 10,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  sram_like_data_responder_if.slave  bus,
  output logic [$clog2(DEPTH):0]     outstanding
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            WORDS    = 1 << AW;
  localparam logic [PW:0]   DEPTH_V  = (PW+1)'(DEPTH);
  localparam logic [3:0]    CNT_INIT = 4'(LATENCY - 1);

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic [DEPTH-1:0] valid_reg;
  logic [3:0]    cnt_reg  [DEPTH];
  logic [31:0]   data_reg [DEPTH];

  logic [AW-1:0] word_idx;
  logic [31:0]   ram_rdata;
  logic [31:0]   push_data;
  logic          accept;
  logic          pop;

  // Size and the non-index address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[31:AW+2],
                         bus.data_sram_addr[1:0]};

  assign word_idx = bus.data_sram_addr[AW+1:2];

  // A pop in this cycle does not open a slot until the next cycle.
  assign bus.data_sram_addr_ok = bus.data_sram_req && (count_reg < DEPTH_V);
  assign accept = bus.data_sram_req && bus.data_sram_addr_ok;

  // Only the head may complete, which keeps responses in acceptance order.
  assign pop = valid_reg[rd_ptr_reg] && (cnt_reg[rd_ptr_reg] == 4'd0);

  assign bus.data_sram_data_ok = pop;
  assign bus.data_sram_rdata   = pop ? data_reg[rd_ptr_reg] : 32'h0;
  assign outstanding           = count_reg;

  // One byte-wide RAM per lane so each byte enable is a plain write enable.
  // The load word is sampled into the queue entry at the accept edge, so it
  // sees every store committed on earlier edges.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];

      always_ff @(posedge clk) begin
        if (accept && bus.data_sram_wr && bus.data_sram_wstrb[gi])
          lane_mem[word_idx] <= bus.data_sram_wdata[8*gi +: 8];
      end

      assign ram_rdata[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  assign push_data = bus.data_sram_wr ? 32'h0 : ram_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)    rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({accept, pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Per-entry valid and countdown. A push never targets the slot being
  // popped, because pushing is blocked while the queue is full.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_reg[i] <= 1'b0;
        cnt_reg[i]   <= 4'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && (wr_ptr_reg == PW'(i))) begin
          valid_reg[i] <= 1'b1;
          cnt_reg[i]   <= CNT_INIT;
        end else begin
          if (pop && (rd_ptr_reg == PW'(i)))
            valid_reg[i] <= 1'b0;
          if (valid_reg[i] && (cnt_reg[i] != 4'd0))
            cnt_reg[i] <= cnt_reg[i] - 4'd1;
        end
      end
    end
  end

  // Payload needs no reset: it is only visible while its valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (wr_ptr_reg == PW'(i)))
        data_reg[i] <= push_data;
    end
  end

endmodule
